// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Writeback request, register-file write and bypass signals
//               shared between the writeback arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;

    logic        l_valid;
    logic [4:0]  l_rd;
    logic [31:0] l_data;
    logic        l_ready;

    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;

    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data, l_valid, l_rd, l_data, q_rs1, q_rs2,
        output a_ready, l_ready, rf_we, rf_wR, rf_wD,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    // Requesters / register-file side
    modport master (
        output a_valid, a_rd, a_data, l_valid, l_rd, l_data, q_rs1, q_rs2,
        input  a_ready, l_ready, rf_we, rf_wR, rf_wD,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Round-robin arbiter between ALU and load-unit writeback,
//               registered RF write port, optional read bypass (WB_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter (
    input  wire logic   cpu_clk,
    input  wire logic   cpu_rst_n,
    wb_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        GRANT_ALU  = 1'b0,
        GRANT_LOAD = 1'b1
    } grant_e;

    grant_e      r_last_grant;
    grant_e      w_last_grant_nxt;
    logic        w_contested;
    logic        w_a_gnt;
    logic        w_l_gnt;

    logic        r_rf_we;
    logic [4:0]  r_rf_wR;
    logic [31:0] r_rf_wD;
    logic        w_rf_we_nxt;
    logic [4:0]  w_rf_wR_nxt;
    logic [31:0] w_rf_wD_nxt;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_last_grant <= GRANT_ALU;
            r_rf_we      <= 1'b0;
            r_rf_wR      <= 5'd0;
            r_rf_wD      <= 32'd0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_rf_we      <= w_rf_we_nxt;
            r_rf_wR      <= w_rf_wR_nxt;
            r_rf_wD      <= w_rf_wD_nxt;
        end
    end

    always_comb begin
        w_contested      = bus.a_valid && bus.l_valid;
        w_a_gnt          = 1'b0;
        w_l_gnt          = 1'b0;
        w_last_grant_nxt = r_last_grant;
        w_rf_we_nxt      = 1'b0;
        w_rf_wR_nxt      = r_rf_wR;
        w_rf_wD_nxt      = r_rf_wD;

        // Readies stay low while reset is held so no transfer can occur.
        if (cpu_rst_n) begin
            if (w_contested) begin
                if (r_last_grant == GRANT_ALU) begin
                    w_l_gnt          = 1'b1;
                    w_last_grant_nxt = GRANT_LOAD;
                end else begin
                    w_a_gnt          = 1'b1;
                    w_last_grant_nxt = GRANT_ALU;
                end
            end else begin
                w_a_gnt = bus.a_valid;
                w_l_gnt = bus.l_valid;
            end
        end

        // x0 writes complete the handshake but never reach the register file.
        if (w_a_gnt && (bus.a_rd != 5'd0)) begin
            w_rf_we_nxt = 1'b1;
            w_rf_wR_nxt = bus.a_rd;
            w_rf_wD_nxt = bus.a_data;
        end else if (w_l_gnt && (bus.l_rd != 5'd0)) begin
            w_rf_we_nxt = 1'b1;
            w_rf_wR_nxt = bus.l_rd;
            w_rf_wD_nxt = bus.l_data;
        end
    end

    assign bus.a_ready = w_a_gnt;
    assign bus.l_ready = w_l_gnt;
    assign bus.rf_we   = r_rf_we;
    assign bus.rf_wR   = r_rf_wR;
    assign bus.rf_wD   = r_rf_wD;

`ifdef WB_FWD_EN
    logic        r_fwd_hit1;
    logic        r_fwd_hit2;
    logic [31:0] r_fwd_data1;
    logic [31:0] r_fwd_data2;

    // Catches reads issued in the same cycle the RF commits the write.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_fwd_hit1  <= 1'b0;
            r_fwd_hit2  <= 1'b0;
            r_fwd_data1 <= 32'd0;
            r_fwd_data2 <= 32'd0;
        end else begin
            r_fwd_hit1  <= r_rf_we && (r_rf_wR == bus.q_rs1) && (bus.q_rs1 != 5'd0);
            r_fwd_hit2  <= r_rf_we && (r_rf_wR == bus.q_rs2) && (bus.q_rs2 != 5'd0);
            r_fwd_data1 <= r_rf_wD;
            r_fwd_data2 <= r_rf_wD;
        end
    end

    assign bus.fwd_hit1  = r_fwd_hit1;
    assign bus.fwd_hit2  = r_fwd_hit2;
    assign bus.fwd_data1 = r_fwd_data1;
    assign bus.fwd_data2 = r_fwd_data2;
`else
    logic w_unused_q_rs;

    assign w_unused_q_rs = ^{bus.q_rs1, bus.q_rs2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = 32'd0;
    assign bus.fwd_data2 = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Scoreboard bench for wb_arbiter: expected RF writes queued at
//               issue, popped by an independent write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

`ifdef WB_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: every committed RF write must match the oldest expectation on time.
    always @(negedge cpu_clk) begin
        if (cpu_rst_n) begin
            if (bus.rf_we == 1'b1) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_write_we", 32'(bus.rf_we), 32'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check("wr_cycle", cyc, e.due);
                    check("wr_rd", 32'(bus.rf_wR), 32'(e.rd));
                    check("wr_data", bus.rf_wD, e.data);
                end
            end else if (q_exp.size() > 0 && q_exp[0].due <= cyc) begin
                check("missing_write_we", 32'(bus.rf_we), 32'd1);
                void'(q_exp.pop_front());
            end
        end
    end

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic ea, input logic el, input string tag);
        @(negedge cpu_clk);
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_data  = ad;
        bus.l_valid = lv;
        bus.l_rd    = lrd;
        bus.l_data  = ld;
        #1;
        check({tag, "_a_ready"}, 32'(bus.a_ready), 32'(ea));
        check({tag, "_l_ready"}, 32'(bus.l_ready), 32'(el));
        if (ea && ard != 5'd0) q_exp.push_back('{ard, ad, cyc + 1});
        if (el && lrd != 5'd0) q_exp.push_back('{lrd, ld, cyc + 1});
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic check_fwd(input string tag, input logic h1, input logic h2,
                             input logic [31:0] d1, input logic [31:0] d2);
        check({tag, "_hit1"}, 32'(bus.fwd_hit1), 32'(h1));
        check({tag, "_hit2"}, 32'(bus.fwd_hit2), 32'(h2));
        check({tag, "_data1"}, bus.fwd_data1, d1);
        check({tag, "_data2"}, bus.fwd_data2, d2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 32'h1;
        bus.l_valid = 1'b1;
        bus.l_rd    = 5'd6;
        bus.l_data  = 32'h2;
        bus.q_rs1   = 5'd0;
        bus.q_rs2   = 5'd0;

        // Reset state with requests pending
        repeat (2) @(negedge cpu_clk);
        #1;
        check("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("rst_l_ready", 32'(bus.l_ready), 32'd0);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_wR", 32'(bus.rf_wR), 32'd0);
        check("rst_rf_wD", bus.rf_wD, 32'd0);
        check_fwd("rst_fwd", 1'b0, 1'b0, 32'd0, 32'd0);
        bus.a_valid = 1'b0;
        bus.l_valid = 1'b0;
        cpu_rst_n   = 1'b1;

        // Single ALU request
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "alu_only");
        idle("idle0");

        // Contested round-robin: L, A, L, A
        drive(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd2, 32'hB000_0001, 1'b0, 1'b1, "rr0");
        drive(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd2, 32'hB000_0002, 1'b1, 1'b0, "rr1");
        drive(1'b1, 5'd1, 32'hA000_0002, 1'b1, 5'd2, 32'hB000_0002, 1'b0, 1'b1, "rr2");
        drive(1'b1, 5'd1, 32'hA000_0002, 1'b1, 5'd2, 32'hB000_0003, 1'b1, 1'b0, "rr3");
        idle("idle1");

        // Load to x0: handshake completes, no RF write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, "ld_x0");
        idle("idle2");
        idle("idle3");

        // Same destination back to back, grant order preserved
        drive(1'b1, 5'd9, 32'h0000_0011, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "same_rd_a");
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0022, 1'b0, 1'b1, "same_rd_l");
        idle("idle4");

        // Bypass: read presented in the cycle the RF commits rd=7
        drive(1'b1, 5'd7, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "fwd_wr");
        @(negedge cpu_clk);
        bus.a_valid = 1'b0;
        bus.q_rs1   = 5'd7;
        bus.q_rs2   = 5'd7;
        @(negedge cpu_clk);
        #1;
        check_fwd("fwd_both", FWD, FWD, FWD ? 32'hAA : 32'd0, FWD ? 32'hAA : 32'd0);
        bus.q_rs1 = 5'd0;
        bus.q_rs2 = 5'd0;

        drive(1'b1, 5'd7, 32'h0000_00BB, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "fwd_wr2");
        @(negedge cpu_clk);
        bus.a_valid = 1'b0;
        bus.q_rs1   = 5'd0;
        bus.q_rs2   = 5'd7;
        @(negedge cpu_clk);
        #1;
        check_fwd("fwd_rs1_x0", 1'b0, FWD, FWD ? 32'hBB : 32'd0, FWD ? 32'hBB : 32'd0);
        // No write committed in the previous cycle: stale-free read
        @(negedge cpu_clk);
        #1;
        check("fwd_nowrite_hit2", 32'(bus.fwd_hit2), 32'd0);
        bus.q_rs2 = 5'd0;

        // Reset asserted while a write is registered
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "pre_rst");
        @(posedge cpu_clk);
        #2;
        check("pre_rst_rf_we", 32'(bus.rf_we), 32'd1);
        cpu_rst_n = 1'b0;
        q_exp.delete();
        #1;
        check("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("mid_rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("mid_rst_rf_wR", 32'(bus.rf_wR), 32'd0);
        check_fwd("mid_rst_fwd", 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge cpu_clk);
        bus.a_valid = 1'b0;
        cpu_rst_n   = 1'b1;

        // last_grant back at ALU: first contested grant goes to LOAD
        drive(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd6, 32'h0000_0066, 1'b0, 1'b1, "post_rst_rr0");
        drive(1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "post_rst_rr1");
        idle("idle5");
        idle("idle6");
        idle("idle7");

        check("queue_empty", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
